nibble_neg_seq: RTL and testbench
=================================

Name: nibble_neg_seq

Overview:
- Sequential wide two's-complement negator, i.e. dout = -din mod 2^(4*NIBBLES).
- Processes the operand one nibble per cycle, LSB nibble first, through a single 4-bit complement stage.
- Controls that stage with a "first one seen" flag, so no wide adder or wide combinational negation is needed.
- Sits beside the 4-bit complement datapath and sequences it for operands wider than 4 bits.

Parameters:
- NIBBLES, 4, number of 4-bit nibbles in the operand (operand width = 4*NIBBLES). Legal range 1..16.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request to negate din; sampled only in IDLE.
- din  input  4*NIBBLES  operand; captured on the accepting edge, may change afterwards.
- busy  output  1  high in RUN and DONE.
- done  output  1  one-cycle pulse; dout, ovf and zero are valid from this cycle.
- dout  output  4*NIBBLES  negated result; holds until the next accepted start.
- ovf  output  1  operand was the most negative value (only MSB set); dout equals din in this case.
- zero  output  1  operand was zero; dout = 0.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE; busy=0, done=0, dout=0, ovf=0, zero=0.
  - Internal operand register, nibble index and seen-one flag cleared.
- States: IDLE -> RUN -> DONE -> IDLE.
- IDLE:
  - start=1 at an edge: capture din into the operand register, index=0, seen=0, state->RUN.
  - Clear ovf/zero on that same edge.
- RUN, one nibble k=index per edge:
  - If seen=0: result nibble = 4-bit two's complement of operand nibble k (low bit copied, bits above the first 1 inverted).
  - If seen=1: result nibble = bitwise NOT of operand nibble k.
  - Write the result nibble into dout[4k+3:4k]; seen <= seen | (nibble k != 0).
  - On the edge processing k=NIBBLES-1: state->DONE.
- DONE:
  - done=1 for exactly one cycle; state->IDLE on the next edge.
  - zero = (seen==0 after all nibbles).
  - ovf = 1 when the operand MSB is 1 and all lower bits are 0.
- Latency: start sampled at edge E0 -> done high in the cycle after edge E(NIBBLES) -> IDLE at E(NIBBLES+1). Throughput is one operation per NIBBLES+2 cycles.
- dout during RUN:
  - Nibbles below index already hold the new result; nibbles at or above index still hold the previous result.
  - dout is only guaranteed valid when done=1 and afterwards.
- start while busy=1 is ignored (not queued). start in the cycle done=1 is also ignored.
- din changes after the accepting edge have no effect.
- NIBBLES=1: RUN lasts one edge; the result matches the 4-bit complement stage exactly.
- Reset mid-operation aborts immediately to the reset values; there is no partial done.
- Arithmetic is modulo 2^(4*NIBBLES), with no sign extension.

Test Plan:
- NIBBLES=4, din=0x0001, start pulse -> done 5 cycles after the start edge, dout=0xFFFF, ovf=0, zero=0; busy high for exactly 5 cycles.
- din=0x0000 -> dout=0x0000, zero=1, ovf=0.
- din=0x8000 -> dout=0x8000, ovf=1. din=0x7FFF -> dout=0x8001, ovf=0.
- din=0x1230 (trailing zero nibble exercises the seen flag) -> dout=0xEDD0. din=0xFFFF -> dout=0x0001.
- Second start asserted mid-RUN and in the done cycle -> ignored, single done pulse. A start in the following IDLE cycle with din=0x0010 -> dout=0xFFF0.
- rst_n low at RUN index 2 -> all outputs 0 immediately, no done pulse. Next start with din=0x0005 -> dout=0xFFFB.
- Random compare against -din for NIBBLES=1 and NIBBLES=8.

Source files
------------

// File: rtl/nibble_neg_seq.sv
// Sequential two's-complement negator: one nibble per cycle, LSB first, through a
// single 4-bit complement stage steered by a "first one seen" flag.
module nibble_neg_seq #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [4*NIBBLES-1:0]   din,
  output logic                   busy,
  output logic                   done,
  output logic [4*NIBBLES-1:0]   dout,
  output logic                   ovf,
  output logic                   zero
);

  localparam int W  = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};

  // Handshake: start is accepted only on an edge where busy=0; done is a
  // one-cycle pulse and results hold until the next accepted start.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [IW-1:0]   r_idx;
  logic            r_seen;
  logic [W-1:0]    r_op;
  logic [W-1:0]    r_dout;
  logic            r_ovf;
  logic            r_zero;
  logic [3:0]      w_nib;
  logic [3:0]      w_res;
  logic            w_nib_nz;
  logic            w_last;

  always_comb begin
    w_nib = 4'd0;
    for (int k = 0; k < NIBBLES; k++) begin
      if (r_idx == IW'(k)) w_nib = r_op[4*k +: 4];
    end
  end

  // Before the first 1 the stage negates; after it, only inversion remains.
  always_comb begin
    w_res    = r_seen ? ~w_nib : (~w_nib + 4'd1);
    w_nib_nz = (w_nib != 4'd0);
    w_last   = (r_idx == IW'(NIBBLES - 1));
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_RUN;
      S_RUN:   if (w_last) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op   <= '0;
      r_idx  <= '0;
      r_seen <= 1'b0;
      r_dout <= '0;
      r_ovf  <= 1'b0;
      r_zero <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_op   <= din;
            r_idx  <= '0;
            r_seen <= 1'b0;
            r_ovf  <= 1'b0;
            r_zero <= 1'b0;
          end
        end
        S_RUN: begin
          for (int k = 0; k < NIBBLES; k++) begin
            if (r_idx == IW'(k)) r_dout[4*k +: 4] <= w_res;
          end
          r_seen <= r_seen | w_nib_nz;
          if (w_last) begin
            r_zero <= ~(r_seen | w_nib_nz);
            r_ovf  <= (r_op == MIN_NEG);
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (r_state != S_IDLE);
  assign done = (r_state == S_DONE);
  assign dout = r_dout;
  assign ovf  = r_ovf;
  assign zero = r_zero;

endmodule

// File: tb/tb_nibble_neg_seq.sv
// Directed and randomized checks of nibble_neg_seq at NIBBLES = 4, 1 and 8.
module tb_nibble_neg_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  // NIBBLES=4 instance
  logic        s4 = 1'b0;
  logic [15:0] d4 = '0;
  logic        b4, dn4, ov4, z4;
  logic [15:0] q4;
  nibble_neg_seq #(.NIBBLES(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(s4), .din(d4),
    .busy(b4), .done(dn4), .dout(q4), .ovf(ov4), .zero(z4)
  );

  // NIBBLES=1 instance
  logic       s1 = 1'b0;
  logic [3:0] d1 = '0;
  logic       b1, dn1, ov1, z1;
  logic [3:0] q1;
  nibble_neg_seq #(.NIBBLES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(s1), .din(d1),
    .busy(b1), .done(dn1), .dout(q1), .ovf(ov1), .zero(z1)
  );

  // NIBBLES=8 instance
  logic        s8 = 1'b0;
  logic [31:0] d8 = '0;
  logic        b8, dn8, ov8, z8;
  logic [31:0] q8;
  nibble_neg_seq #(.NIBBLES(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(s8), .din(d8),
    .busy(b8), .done(dn8), .dout(q8), .ovf(ov8), .zero(z8)
  );

  // Driver: one-cycle start pulse; returns at the first negedge after acceptance,
  // then scrambles din to show later changes are ignored.
  task automatic start4(input logic [15:0] v);
    @(negedge clk);
    s4 = 1'b1;
    d4 = v;
    @(negedge clk);
    s4 = 1'b0;
    d4 = 16'($urandom);
  endtask

  // Waits (bounded) for done; cyc counts negedges since the accepting edge.
  task automatic wait4(output int cyc, output int busy_cnt);
    cyc = 1;
    busy_cnt = b4 ? 1 : 0;
    while (!dn4 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (b4) busy_cnt++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #3;
    checks++; if (b4 !== 1'b0)     begin failures++; $display("FAIL reset_busy: got %b expected 0", b4); end
    checks++; if (dn4 !== 1'b0)    begin failures++; $display("FAIL reset_done: got %b expected 0", dn4); end
    checks++; if (q4 !== 16'h0000) begin failures++; $display("FAIL reset_dout: got %h expected 0000", q4); end
    checks++; if (ov4 !== 1'b0)    begin failures++; $display("FAIL reset_ovf: got %b expected 0", ov4); end
    checks++; if (z4 !== 1'b0)     begin failures++; $display("FAIL reset_zero: got %b expected 0", z4); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic;
    int cyc, bc;
    start4(16'h0001);
    wait4(cyc, bc);
    checks++; if (cyc != 5)        begin failures++; $display("FAIL basic_latency: got %0d expected 5", cyc); end
    checks++; if (q4 !== 16'hFFFF) begin failures++; $display("FAIL basic_dout: got %h expected ffff", q4); end
    checks++; if (ov4 !== 1'b0)    begin failures++; $display("FAIL basic_ovf: got %b expected 0", ov4); end
    checks++; if (z4 !== 1'b0)     begin failures++; $display("FAIL basic_zero: got %b expected 0", z4); end
    @(negedge clk);
    if (b4) bc++;
    checks++; if (bc != 5)         begin failures++; $display("FAIL basic_busy_cycles: got %0d expected 5", bc); end
    checks++; if (dn4 !== 1'b0)    begin failures++; $display("FAIL basic_done_pulse: got %b expected 0", dn4); end
    checks++; if (q4 !== 16'hFFFF) begin failures++; $display("FAIL basic_hold: got %h expected ffff", q4); end
  endtask

  task automatic test_patterns;
    logic [15:0] vin [5]  = '{16'h0000, 16'h8000, 16'h7FFF, 16'h1230, 16'hFFFF};
    logic [15:0] vexp [5] = '{16'h0000, 16'h8000, 16'h8001, 16'hEDD0, 16'h0001};
    logic        eovf [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic        ezer [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    int cyc, bc;
    for (int i = 0; i < 5; i++) begin
      start4(vin[i]);
      wait4(cyc, bc);
      checks++; if (cyc != 5)       begin failures++; $display("FAIL pat_latency[%h]: got %0d expected 5", vin[i], cyc); end
      checks++; if (q4 !== vexp[i]) begin failures++; $display("FAIL pat_dout[%h]: got %h expected %h", vin[i], q4, vexp[i]); end
      checks++; if (ov4 !== eovf[i]) begin failures++; $display("FAIL pat_ovf[%h]: got %b expected %b", vin[i], ov4, eovf[i]); end
      checks++; if (z4 !== ezer[i]) begin failures++; $display("FAIL pat_zero[%h]: got %b expected %b", vin[i], z4, ezer[i]); end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back;
    int cyc, bc;
    start4(16'h1111);
    @(negedge clk);
    s4 = 1'b1;
    d4 = 16'h2222;
    @(negedge clk);
    s4 = 1'b0;
    cyc = 3;
    while (!dn4 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    checks++; if (cyc != 5)        begin failures++; $display("FAIL b2b_latency: got %0d expected 5", cyc); end
    checks++; if (q4 !== 16'hEEEF) begin failures++; $display("FAIL b2b_dout: got %h expected eeef", q4); end
    s4 = 1'b1;
    d4 = 16'h3333;
    @(negedge clk);
    checks++; if (b4 !== 1'b0)     begin failures++; $display("FAIL b2b_done_start_ignored: busy got %b expected 0", b4); end
    checks++; if (dn4 !== 1'b0)    begin failures++; $display("FAIL b2b_single_done: got %b expected 0", dn4); end
    checks++; if (q4 !== 16'hEEEF) begin failures++; $display("FAIL b2b_hold: got %h expected eeef", q4); end
    d4 = 16'h0010;
    @(negedge clk);
    s4 = 1'b0;
    wait4(cyc, bc);
    checks++; if (cyc != 5)        begin failures++; $display("FAIL b2b_next_latency: got %0d expected 5", cyc); end
    checks++; if (q4 !== 16'hFFF0) begin failures++; $display("FAIL b2b_next_dout: got %h expected fff0", q4); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int cyc, bc, stray;
    start4(16'h1234);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (b4 !== 1'b0)     begin failures++; $display("FAIL rmid_busy: got %b expected 0", b4); end
    checks++; if (q4 !== 16'h0000) begin failures++; $display("FAIL rmid_dout: got %h expected 0000", q4); end
    checks++; if (ov4 !== 1'b0 || z4 !== 1'b0) begin failures++; $display("FAIL rmid_flags: got ovf=%b zero=%b expected 0 0", ov4, z4); end
    stray = 0;
    repeat (3) begin
      @(negedge clk);
      if (dn4 || b4) stray++;
    end
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (dn4 || b4) stray++;
    end
    checks++; if (stray != 0)      begin failures++; $display("FAIL rmid_no_done: got %0d active cycles expected 0", stray); end
    start4(16'h0005);
    wait4(cyc, bc);
    checks++; if (cyc != 5)        begin failures++; $display("FAIL rmid_next_latency: got %0d expected 5", cyc); end
    checks++; if (q4 !== 16'hFFFB) begin failures++; $display("FAIL rmid_next_dout: got %h expected fffb", q4); end
    @(negedge clk);
  endtask

  task automatic test_random_n1;
    logic [3:0] v, e;
    int cyc;
    for (int i = 0; i < 24; i++) begin
      v = (i == 0) ? 4'h0 : (i == 1) ? 4'h8 : 4'($urandom_range(0, 15));
      e = 4'd0 - v;
      @(negedge clk);
      s1 = 1'b1;
      d1 = v;
      @(negedge clk);
      s1 = 1'b0;
      d1 = 4'($urandom);
      cyc = 1;
      while (!dn1 && cyc < 20) begin
        @(negedge clk);
        cyc++;
      end
      checks++; if (cyc != 2) begin failures++; $display("FAIL n1_latency[%h]: got %0d expected 2", v, cyc); end
      checks++; if (q1 !== e || ov1 !== (v == 4'h8) || z1 !== (v == 4'h0)) begin
        failures++;
        $display("FAIL n1_result[%h]: got dout=%h ovf=%b zero=%b expected dout=%h ovf=%b zero=%b",
                 v, q1, ov1, z1, e, (v == 4'h8), (v == 4'h0));
      end
    end
  endtask

  task automatic test_random_n8;
    logic [31:0] v, e;
    int cyc;
    for (int i = 0; i < 24; i++) begin
      v = (i == 0) ? 32'h0 : (i == 1) ? 32'h8000_0000 : (i == 2) ? 32'h0100_0000 : $urandom;
      e = 32'd0 - v;
      @(negedge clk);
      s8 = 1'b1;
      d8 = v;
      @(negedge clk);
      s8 = 1'b0;
      d8 = $urandom;
      cyc = 1;
      while (!dn8 && cyc < 40) begin
        @(negedge clk);
        cyc++;
      end
      checks++; if (cyc != 9) begin failures++; $display("FAIL n8_latency[%h]: got %0d expected 9", v, cyc); end
      checks++; if (q8 !== e || ov8 !== (v == 32'h8000_0000) || z8 !== (v == 32'h0)) begin
        failures++;
        $display("FAIL n8_result[%h]: got dout=%h ovf=%b zero=%b expected dout=%h ovf=%b zero=%b",
                 v, q8, ov8, z8, e, (v == 32'h8000_0000), (v == 32'h0));
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_patterns();
    test_back_to_back();
    test_reset_mid();
    test_random_n1();
    test_random_n8();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
